led_mux6_scan: RTL and testbench

Six-digit time-multiplexed seven-segment driver for the rotating banner display. It sits directly downstream of the banner rotator and consumes its six 5-bit digit codes `in0`..`in5`, each formatted as {decimal point, hex nibble}. It scans one common-anode digit at a time, with these features:
- ghost-suppression blanking at the start of every digit slot;
- 8-level PWM brightness;
- per-digit blanking;
- a frame-synchronous snapshot of all inputs, so that a banner shift never tears across digits within one frame.

---
 rtl/led_mux6_scan.sv | 139 +++++++++++++
 tb/tb_led_mux6_scan.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mux6_scan.sv
// Six-digit time-multiplexed seven-segment driver for the rotating banner.
// Scans one common-anode digit per slot, blanks the start of every slot to
// suppress ghosting, applies 8-level PWM brightness and per-digit masking,
// and latches all inputs once per frame so a banner shift never tears.
module led_mux6_scan #(
    parameter int N_REFRESH = 50_000,  // clk cycles per digit slot
    parameter int BLANK     = 1_000    // dark cycles at the start of each slot, >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] in0,
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    input  logic [4:0] in3,
    input  logic [4:0] in4,
    input  logic [4:0] in5,
    input  logic [2:0] bright,
    input  logic [5:0] blank_mask,
    output logic [5:0] an,
    output logic [7:0] seg,
    output logic       frame_tick
);

    // Usable lit window per slot; must be a positive multiple of 8.
    localparam int L    = N_REFRESH - BLANK;
    localparam int STEP = L / 8;
    localparam int CW   = $clog2(N_REFRESH);
    // Wide enough for STEP * 8 and for the slot counter itself.
    localparam int OW   = CW + 3;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] p;
        case (h)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    logic [2:0]      d;           // digit index 0..5
    logic [CW-1:0]   c;           // position within the slot
    logic            last_c;
    logic            frame_start;

    logic [5:0][4:0] sh_code;     // frame snapshot of in0..in5
    logic [2:0]      sh_bright;
    logic [5:0]      sh_mask;

    logic [4:0]      code_sel;
    logic            mask_sel;
    logic [OW-1:0]   on_len;
    logic            in_window;
    logic            lit;

    assign last_c      = (c == CW'(N_REFRESH - 1));
    assign frame_start = (d == 3'd0) && (c == '0);

    // Scan counters: c counts through the slot, d advances and wraps 5 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            d <= 3'd0;
            c <= '0;
        end else if (last_c) begin
            c <= '0;
            d <= (d == 3'd5) ? 3'd0 : d + 3'd1;
        end else begin
            c <= c + CW'(1);
        end
    end

    // Frame snapshot, taken on the edge that leaves state (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shadow bank is small and must read as zero before the
        // first snapshot, so it is reset like ordinary control state.
        if (!rst_n) begin
            sh_code   <= '0;
            sh_bright <= 3'd0;
            sh_mask   <= 6'd0;
        end else if (frame_start) begin
            sh_code   <= {in5, in4, in3, in2, in1, in0};
            sh_bright <= bright;
            sh_mask   <= blank_mask;
        end
    end

    // Pick the shadow code and mask bit for the digit being scanned.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a
        // variable unassigned and infers a latch.
        code_sel = sh_code[0];
        mask_sel = sh_mask[0];
        case (d)
            3'd1: begin code_sel = sh_code[1]; mask_sel = sh_mask[1]; end
            3'd2: begin code_sel = sh_code[2]; mask_sel = sh_mask[2]; end
            3'd3: begin code_sel = sh_code[3]; mask_sel = sh_mask[3]; end
            3'd4: begin code_sel = sh_code[4]; mask_sel = sh_mask[4]; end
            3'd5: begin code_sel = sh_code[5]; mask_sel = sh_mask[5]; end
            default: ;
        endcase
    end

    // Lit decision: past the blanking prefix, inside the PWM window, not masked.
    always_comb begin
        on_len    = OW'(STEP) * (OW'(sh_bright) + OW'(1));
        in_window = (OW'(c) >= OW'(BLANK)) && ((OW'(c) - OW'(BLANK)) < on_len);
        lit       = in_window && !mask_sel;
    end

    // Registered outputs, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 6'h3F;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= lit ? ~(6'b1 << d) : 6'h3F;
            seg        <= lit ? ~{code_sel[4], hex7(code_sel[3:0])} : 8'hFF;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_led_mux6_scan.sv
// Self-checking bench for led_mux6_scan with N_REFRESH=24, BLANK=8.
// A frame-level reference model tracks the expected outputs cycle by cycle.
module tb_led_mux6_scan;

    localparam int NR    = 24;
    localparam int BL    = 8;
    localparam int FRAME = 6 * NR;

    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] in_v [6];
    logic [2:0] bright = 3'd0;
    logic [5:0] blank_mask = 6'd0;
    logic [5:0] an;
    logic [7:0] seg;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    led_mux6_scan #(.N_REFRESH(NR), .BLANK(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0        (in_v[0]),
        .in1        (in_v[1]),
        .in2        (in_v[2]),
        .in3        (in_v[3]),
        .in4        (in_v[4]),
        .in5        (in_v[5]),
        .bright     (bright),
        .blank_mask (blank_mask),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         k;            // edges since reset release
    logic [4:0] m_in [6];
    logic [2:0] m_bright;
    logic [5:0] m_mask;
    logic [5:0] exp_an;
    logic [7:0] exp_seg;
    logic       exp_tick;

    function automatic bit model_lit(int p);
        int dd     = p / NR;
        int cc     = p % NR;
        int on_len = ((NR - BL) / 8) * (int'(m_bright) + 1);
        return (cc >= BL) && (cc - BL < on_len) && !m_mask[dd];
    endfunction

    function automatic logic [5:0] model_an(int p);
        return model_lit(p) ? ~(6'd1 << (p / NR)) : 6'h3F;
    endfunction

    function automatic logic [7:0] model_seg(int p);
        logic [4:0] code = m_in[p / NR];
        return model_lit(p) ? ~{code[4], HEX7[code[3:0]]} : 8'hFF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= 0;
            exp_an   <= 6'h3F;
            exp_seg  <= 8'hFF;
            exp_tick <= 1'b0;
            m_bright <= 3'd0;
            m_mask   <= 6'd0;
            for (int i = 0; i < 6; i++) m_in[i] <= 5'd0;
        end else begin
            exp_an   <= model_an(k % FRAME);
            exp_seg  <= model_seg(k % FRAME);
            exp_tick <= ((k % FRAME) == 0);
            if ((k % FRAME) == 0) begin
                m_in     <= in_v;
                m_bright <= bright;
                m_mask   <= blank_mask;
            end
            k <= k + 1;
        end
    end

    // Park on the negedge just before the edge that processes scan state `target`.
    task automatic wait_pos(input int target, input string who);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if ((k % FRAME) == target) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout waiting for scan position %0d", who, target);
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 6; i++) in_v[i] = 5'($urandom_range(0, 31));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_tick = -1;
        int second_tick = -1;
        rst_n = 1'b0;
        randomize_inputs();
        bright = 3'd7;
        blank_mask = 6'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== 6'h3F || seg !== 8'hFF || frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: an=%h seg=%h tick=%b, expected an=3f seg=ff tick=0",
                         an, seg, frame_tick);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 2 * FRAME + 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL reset_run cycle %0d: an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
            if (frame_tick === 1'b1) begin
                if (first_tick < 0) first_tick = i;
                else if (second_tick < 0) second_tick = i;
            end
        end
        n_checks++;
        if (first_tick !== 1) begin
            n_fail++;
            $display("FAIL first_tick: at cycle %0d, expected 1", first_tick);
        end
        n_checks++;
        if (second_tick - first_tick !== FRAME) begin
            n_fail++;
            $display("FAIL tick_period: %0d, expected %0d", second_tick - first_tick, FRAME);
        end
    endtask

    task automatic test_decode();
        int cnt0 = 0, cnt5 = 0, cnt_dark = 0;
        randomize_inputs();
        in_v[0] = 5'h00;
        in_v[5] = 5'h1A;
        bright = 3'd7;
        blank_mask = 6'd0;
        wait_pos(0, "decode");
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL decode cycle %0d: an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
            if (an === 6'h3E && seg === 8'hC0) cnt0++;
            if (an === 6'h1F && seg === 8'h08) cnt5++;
            if (an === 6'h3F) cnt_dark++;
        end
        n_checks++;
        if (cnt0 !== 16) begin
            n_fail++;
            $display("FAIL decode_digit0: %0d lit cycles of 3e/c0, expected 16", cnt0);
        end
        n_checks++;
        if (cnt5 !== 16) begin
            n_fail++;
            $display("FAIL decode_digit5: %0d lit cycles of 1f/08, expected 16", cnt5);
        end
        n_checks++;
        if (cnt_dark !== 6 * BL) begin
            n_fail++;
            $display("FAIL decode_dark: %0d dark cycles, expected %0d", cnt_dark, 6 * BL);
        end
    endtask

    task automatic test_brightness();
        for (int t = 0; t < 5; t++) begin
            int act [6];
            int total = 0, want = 0;
            randomize_inputs();
            if (t == 0) begin bright = 3'd0; blank_mask = 6'd0; end
            else if (t == 1) begin bright = 3'd3; blank_mask = 6'd0; end
            else begin
                bright = 3'($urandom_range(0, 7));
                blank_mask = 6'($urandom_range(0, 63));
            end
            for (int j = 0; j < 6; j++) act[j] = 0;
            wait_pos(0, "brightness");
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                n_checks++;
                if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                    n_fail++;
                    $display("FAIL brightness trial %0d cycle %0d: an=%h seg=%h, expected an=%h seg=%h",
                             t, i, an, seg, exp_an, exp_seg);
                end
                if (an !== 6'h3F) begin
                    act[i / NR]++;
                    total++;
                end
            end
            for (int j = 0; j < 6; j++)
                if (!blank_mask[j]) want += 2 * (int'(bright) + 1);
            n_checks++;
            if (total !== want) begin
                n_fail++;
                $display("FAIL brightness_total trial %0d (bright=%0d mask=%b): %0d active, expected %0d",
                         t, bright, blank_mask, total, want);
            end
            if (t < 2) begin
                for (int j = 0; j < 6; j++) begin
                    n_checks++;
                    if (act[j] !== 2 * (int'(bright) + 1)) begin
                        n_fail++;
                        $display("FAIL brightness_slot%0d bright=%0d: %0d active, expected %0d",
                                 j, bright, act[j], 2 * (int'(bright) + 1));
                    end
                end
            end
        end
    endtask

    task automatic test_blank_mask();
        int cnt2 = 0, cnt_lit = 0;
        randomize_inputs();
        bright = 3'd7;
        blank_mask = 6'b000100;
        wait_pos(0, "blank_mask");
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL blank_mask cycle %0d: an=%h seg=%h, expected an=%h seg=%h",
                         i, an, seg, exp_an, exp_seg);
            end
            if (an[2] === 1'b0) cnt2++;
            if (an !== 6'h3F) cnt_lit++;
        end
        n_checks++;
        if (cnt2 !== 0) begin
            n_fail++;
            $display("FAIL blank_mask_digit2: %0d lit cycles, expected 0", cnt2);
        end
        n_checks++;
        if (cnt_lit !== 80) begin
            n_fail++;
            $display("FAIL blank_mask_others: %0d lit cycles, expected 80", cnt_lit);
        end
        blank_mask = 6'd0;
    endtask

    task automatic test_tear_free();
        int cnt_old = 0, cnt_new = 0;
        randomize_inputs();
        in_v[3] = 5'h03;
        bright = 3'd7;
        blank_mask = 6'd0;
        wait_pos(0, "tear_free");
        wait_pos(NR + 6, "tear_free_slot1");
        in_v[3] = 5'h07;
        for (int i = NR + 6; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++;
                $display("FAIL tear_free cycle %0d: an=%h seg=%h, expected an=%h seg=%h",
                         i, an, seg, exp_an, exp_seg);
            end
            if (i < FRAME && an === 6'h37 && seg === 8'hB0) cnt_old++;
            if (i >= FRAME && an === 6'h37 && seg === 8'hF8) cnt_new++;
        end
        n_checks++;
        if (cnt_old !== 16) begin
            n_fail++;
            $display("FAIL tear_free_old: %0d cycles of 37/b0, expected 16", cnt_old);
        end
        n_checks++;
        if (cnt_new !== 16) begin
            n_fail++;
            $display("FAIL tear_free_new: %0d cycles of 37/f8, expected 16", cnt_new);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] want_seg;
        bit         seen = 1'b0;
        bright = 3'd7;
        blank_mask = 6'd0;
        wait_pos(3 * NR + BL + 4, "async_reset");
        n_checks++;
        if (an !== 6'h37) begin
            n_fail++;
            $display("FAIL async_pre: an=%h, expected 37", an);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (an !== 6'h3F || seg !== 8'hFF || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_immediate: an=%h seg=%h tick=%b, expected an=3f seg=ff tick=0",
                     an, seg, frame_tick);
        end
        randomize_inputs();
        want_seg = ~{in_v[0][4], HEX7[in_v[0][3:0]]};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME && !seen; i++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || frame_tick !== exp_tick) begin
                n_fail++;
                $display("FAIL async_run cycle %0d: an=%h seg=%h tick=%b, expected an=%h seg=%h tick=%b",
                         i, an, seg, frame_tick, exp_an, exp_seg, exp_tick);
            end
            if (an !== 6'h3F) begin
                seen = 1'b1;
                n_checks++;
                if (an !== 6'h3E || seg !== want_seg) begin
                    n_fail++;
                    $display("FAIL async_first_lit: an=%h seg=%h, expected an=3e seg=%h",
                             an, seg, want_seg);
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL async_no_lit: no lit digit within one frame after release");
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) in_v[i] = 5'd0;
        test_reset();
        test_decode();
        test_brightness();
        test_blank_mask();
        test_tear_free();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
